pe_cfg_mac: RTL and testbench

- Next-generation systolic-array PE: signed scalar MAC with a run-time dataflow mode.
- Modes: input-stationary (IS), weight-stationary (WS), output-stationary (OS).
- Small configuration FSM gates when processing is legal.
- MAC-count telemetry output.
- Tiles into a 2-D array: inputs flow horizontally, weights flow vertically, psums flow vertically or drain in OS mode.

---
 rtl/pe_cfg_mac.sv | 177 +++++++++++++++++
 tb/tb_pe_cfg_mac.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pe_cfg_mac.sv
// Configurable systolic-array PE: signed MAC with IS / WS / OS dataflow modes.
// Build option: define PE_SAT_EN to saturate the accumulator on overflow (default wraps).
module pe_cfg_mac #(
  parameter int INPUT_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int PSUM_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  input  logic [1:0]              cfg_mode,
  input  logic                    load_en,
  input  logic                    process_en,
  input  logic                    drain_en,
  input  logic [INPUT_WIDTH-1:0]  input_in,
  input  logic [WEIGHT_WIDTH-1:0] weight_in,
  input  logic [PSUM_WIDTH-1:0]   psum_in,
  output logic [INPUT_WIDTH-1:0]  input_out,
  output logic [WEIGHT_WIDTH-1:0] weight_out,
  output logic [PSUM_WIDTH-1:0]   psum_out,
  output logic                    psum_valid,
  output logic [1:0]              state,
  output logic [CNT_WIDTH-1:0]    mac_cnt
);

  localparam int PROD_WIDTH = INPUT_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_WIDTH  = PSUM_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_IS = 2'd0,
    MODE_WS = 2'd1,
    MODE_OS = 2'd2
  } mode_t;

  state_t state_q, state_d;
  mode_t  mode_q, cfg_mode_norm;

  logic [INPUT_WIDTH-1:0]  input_q;
  logic [WEIGHT_WIDTH-1:0] weight_q;
  logic [PSUM_WIDTH-1:0]   psum_q;
  logic                    psum_valid_q;
  logic [CNT_WIDTH-1:0]    mac_cnt_q;

  logic do_cfg, do_load, do_mac, do_drain;

  // Reserved mode code 3 behaves as input-stationary.
  always_comb begin
    cfg_mode_norm = MODE_IS;
    case (cfg_mode)
      2'd1:    cfg_mode_norm = MODE_WS;
      2'd2:    cfg_mode_norm = MODE_OS;
      default: cfg_mode_norm = MODE_IS;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_cfg   = 1'b0;
    do_load  = 1'b0;
    do_mac   = 1'b0;
    do_drain = 1'b0;
    if (cfg_valid) begin
      do_cfg  = 1'b1;
      state_d = (cfg_mode_norm == MODE_OS) ? ST_RUN : ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_LOAD: begin
          if (load_en) begin
            do_load = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (mode_q == MODE_OS) begin
            if (drain_en)        do_drain = 1'b1;
            else if (process_en) do_mac   = 1'b1;
          end else begin
            // A concurrent load only lands after this MAC has used the old operand.
            do_mac  = process_en;
            do_load = load_en;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // MAC arithmetic
  // ---------------------------------------------------------------------
  logic signed [INPUT_WIDTH-1:0]  mul_a;
  logic signed [WEIGHT_WIDTH-1:0] mul_b;
  logic signed [PROD_WIDTH-1:0]   prod;
  logic        [SUM_WIDTH-1:0]    prod_ext;
  logic        [SUM_WIDTH-1:0]    addend_ext;
  logic        [SUM_WIDTH-1:0]    sum;
  logic        [PSUM_WIDTH-1:0]   mac_result;
  logic        [PSUM_WIDTH-1:0]   addend;

  always_comb begin
    mul_a      = (mode_q == MODE_IS) ? input_q : input_in;
    mul_b      = (mode_q == MODE_WS) ? weight_q : weight_in;
    prod       = mul_a * mul_b;
    prod_ext   = {{(SUM_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    addend     = (mode_q == MODE_OS) ? psum_q : psum_in;
    addend_ext = {addend[PSUM_WIDTH-1], addend};
    sum        = addend_ext + prod_ext;
`ifdef PE_SAT_EN
    if (sum[SUM_WIDTH-1] != sum[PSUM_WIDTH-1])
      mac_result = sum[SUM_WIDTH-1] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                    : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    else
      mac_result = sum[PSUM_WIDTH-1:0];
`else
    mac_result = sum[PSUM_WIDTH-1:0];
`endif
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q       <= MODE_IS;
      input_q      <= '0;
      weight_q     <= '0;
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
      mac_cnt_q    <= '0;
    end else begin
      psum_valid_q <= do_mac | do_drain;
      if (do_cfg) begin
        mode_q    <= cfg_mode_norm;
        psum_q    <= '0;
        mac_cnt_q <= '0;
        if (cfg_mode_norm == MODE_IS)      input_q  <= '0;
        else if (cfg_mode_norm == MODE_WS) weight_q <= '0;
      end else begin
        if (do_mac) begin
          psum_q <= mac_result;
          if (mac_cnt_q != {CNT_WIDTH{1'b1}}) mac_cnt_q <= mac_cnt_q + 1'b1;
          if (mode_q != MODE_IS) input_q  <= input_in;
          if (mode_q != MODE_WS) weight_q <= weight_in;
        end
        if (do_drain) psum_q <= psum_in;
        if (do_load) begin
          if (mode_q == MODE_IS)      input_q  <= input_in;
          else if (mode_q == MODE_WS) weight_q <= weight_in;
        end
      end
    end
  end

  assign input_out  = input_q;
  assign weight_out = weight_q;
  assign psum_out   = psum_q;
  assign psum_valid = psum_valid_q;
  assign state      = state_q;
  assign mac_cnt    = mac_cnt_q;

endmodule

// File: tb/tb_pe_cfg_mac.sv
// Directed-vector bench for pe_cfg_mac; expected values are hand-computed.
module tb_pe_cfg_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic [1:0]  cfg_mode;
  logic        load_en;
  logic        process_en;
  logic        drain_en;
  logic [15:0] input_in;
  logic [15:0] weight_in;
  logic [31:0] psum_in;
  logic [15:0] input_out;
  logic [15:0] weight_out;
  logic [31:0] psum_out;
  logic        psum_valid;
  logic [1:0]  state;
  logic [15:0] mac_cnt;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pe_cfg_mac #(
    .INPUT_WIDTH(16), .WEIGHT_WIDTH(16), .PSUM_WIDTH(32), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .load_en(load_en), .process_en(process_en), .drain_en(drain_en),
    .input_in(input_in), .weight_in(weight_in), .psum_in(psum_in),
    .input_out(input_out), .weight_out(weight_out), .psum_out(psum_out),
    .psum_valid(psum_valid), .state(state), .mac_cnt(mac_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    cfg_valid = 0; load_en = 0; process_en = 0; drain_en = 0;
  endtask

  task automatic drive(input logic l, input logic p, input logic d,
                       input logic [15:0] a, input logic [15:0] b, input logic [31:0] s);
    quiet();
    load_en = l; process_en = p; drain_en = d;
    input_in = a; weight_in = b; psum_in = s;
    tick();
  endtask

  task automatic cfg(input logic [1:0] m);
    quiet();
    cfg_valid = 1; cfg_mode = m;
    tick();
    cfg_valid = 0;
  endtask

  initial begin
    rst_n = 0; cfg_mode = 0; input_in = 0; weight_in = 0; psum_in = 0;
    quiet();
    // Reset held while process_en is asserted
    process_en = 1; input_in = 3; weight_in = 4;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_psum", psum_out, 32'd0);
    chk("rst_valid", 32'(psum_valid), 32'd0);
    chk("rst_cnt", 32'(mac_cnt), 32'd0);
    rst_n = 1;
    tick();
    chk("idle_ignore_cnt", 32'(mac_cnt), 32'd0);
    chk("idle_ignore_valid", 32'(psum_valid), 32'd0);
    chk("idle_state", 32'(state), 32'd0);

    // IS mode
    cfg(2'd0);
    chk("is_cfg_state", 32'(state), 32'd1);
    drive(0, 1, 0, 16'd9, 16'd9, 32'd9);
    chk("load_ignore_proc_cnt", 32'(mac_cnt), 32'd0);
    chk("load_ignore_state", 32'(state), 32'd1);
    drive(1, 0, 0, 16'd5, 16'd0, 32'd0);
    chk("is_load_state", 32'(state), 32'd2);
    chk("is_load_in_out", 32'(input_out), 32'd5);
    drive(0, 1, 0, 16'd0, -16'sd3, 32'd10);
    chk("is_psum", psum_out, -32'sd5);
    chk("is_w_out", 32'($signed(weight_out)), -32'sd3);
    chk("is_valid", 32'(psum_valid), 32'd1);
    chk("is_cnt", 32'(mac_cnt), 32'd1);
    chk("is_in_hold", 32'(input_out), 32'd5);
    drive(0, 0, 0, 16'd0, 16'd0, 32'd0);
    chk("is_valid_drop", 32'(psum_valid), 32'd0);

    // WS mode with simultaneous load + process
    cfg(2'd1);
    chk("ws_cfg_cnt", 32'(mac_cnt), 32'd0);
    chk("ws_cfg_psum", psum_out, 32'd0);
    drive(1, 0, 0, 16'd0, 16'd2, 32'd0);
    chk("ws_load_w", 32'(weight_out), 32'd2);
    drive(1, 1, 0, 16'd7, 16'd9, 32'd0);
    chk("ws_old_stat_psum", psum_out, 32'd14);
    chk("ws_new_stat", 32'(weight_out), 32'd9);
    chk("ws_fwd_in", 32'(input_out), 32'd7);
    drive(0, 1, 0, 16'd1, 16'd0, 32'd0);
    chk("ws_new_stat_psum", psum_out, 32'd9);
    chk("ws_cnt", 32'(mac_cnt), 32'd2);

    // OS accumulate and drain
    cfg(2'd2);
    chk("os_cfg_state", 32'(state), 32'd2);
    drive(0, 1, 0, 16'd2, 16'd3, 32'd1000);
    drive(0, 1, 0, 16'd4, 16'd5, 32'd1000);
    drive(0, 1, 0, -16'sd1, 16'd6, 32'd1000);
    chk("os_acc", psum_out, 32'd20);
    chk("os_fwd_in", 32'($signed(input_out)), -32'sd1);
    chk("os_fwd_w", 32'(weight_out), 32'd6);
    drive(0, 1, 1, 16'd7, 16'd7, 32'd100);
    chk("os_drain", psum_out, 32'd100);
    chk("os_drain_cnt", 32'(mac_cnt), 32'd3);
    chk("os_drain_valid", 32'(psum_valid), 32'd1);

    // Overflow at the positive rail
    drive(0, 0, 1, 16'd0, 16'd0, 32'h7FFF_FFF0);
    drive(0, 1, 0, 16'd4, 16'd8, 32'd0);
`ifdef PE_SAT_EN
    chk("os_overflow", psum_out, 32'h7FFF_FFFF);
`else
    chk("os_overflow", psum_out, 32'h8000_0010);
`endif

    // Mid-run reconfig with process_en, then reset
    cfg(2'd1);
    drive(1, 0, 0, 16'd0, 16'd1, 32'd0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 16'd1, 16'd0, 32'd0);
    chk("pre_recfg_cnt", 32'(mac_cnt), 32'd5);
    chk("pre_recfg_psum", psum_out, 32'd1);
    quiet();
    cfg_valid = 1; cfg_mode = 2'd0; process_en = 1;
    input_in = 16'd3; weight_in = 16'd3; psum_in = 32'd50;
    tick();
    quiet();
    chk("recfg_psum", psum_out, 32'd0);
    chk("recfg_cnt", 32'(mac_cnt), 32'd0);
    chk("recfg_state", 32'(state), 32'd1);
    chk("recfg_valid", 32'(psum_valid), 32'd0);
    rst_n = 0;
    tick();
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_psum", psum_out, 32'd0);
    chk("rst2_in", 32'(input_out), 32'd0);
    chk("rst2_w", 32'(weight_out), 32'd0);
    chk("rst2_cnt", 32'(mac_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
